// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encoding, oversampling points and divider defaults.
package uart_pkg;

  localparam int unsigned OS_RATE          = 16;
  localparam int unsigned SAMPLE_LO        = 7;
  localparam int unsigned SAMPLE_MID       = 8;
  localparam int unsigned SAMPLE_HI        = 9;
  localparam int unsigned BAUD_DIV_DEFAULT = 22;  // 40 MHz / (16 x 115200), rounded
  localparam int unsigned DIV_W            = 16;
  localparam int unsigned OS_W             = 4;
  localparam int unsigned BIT_W            = 3;
  localparam int unsigned DATA_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: pulses ce16_o once every BAUD_DIV cycles, held at phase 0 by restart_i.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic restart_i,
  output logic ce16_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    ce_d  = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == DIV_W'(BAUD_DIV - 1)) begin
      cnt_d = '0;
      ce_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce16_o = ce_q;

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority vote, false-start rejection,
// optional parity check and framing/break handling.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_in,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  logic             sync1_q, sync2_q, dly_q;
  logic [1:0]       valid_q;
  logic             armed_q;
  logic             start_edge;
  logic             ce16;

  rx_state_e        state_q, state_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             s_lo_q, s_lo_d, s_mid_q, s_mid_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_err_q, par_err_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             new_q, new_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
  logic             maj, at_hi, at_end;

  // Synchronizer plus edge delay; armed_q keeps a line that is low out of reset from looking like a start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
      valid_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= ser_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      valid_q <= {valid_q[0], 1'b1};
      armed_q <= armed_q | (valid_q[1] & sync2_q);
    end
  end

  assign start_edge = armed_q & dly_q & ~sync2_q;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clock     (clock),
    .reset     (reset),
    .restart_i (state_q == ST_IDLE),
    .ce16_o    (ce16)
  );

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    s_lo_d    = s_lo_q;
    s_mid_d   = s_mid_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    rx_data_d = rx_data_q;
    new_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    maj       = majority3(s_lo_q, s_mid_q, sync2_q);
    at_hi     = ce16 && (os_cnt_q == OS_W'(SAMPLE_HI));
    at_end    = ce16 && (os_cnt_q == OS_W'(OS_RATE - 1));

    if (ce16 && (state_q != ST_IDLE)) begin
      os_cnt_d = os_cnt_q + OS_W'(1);
      if (os_cnt_q == OS_W'(SAMPLE_LO))  s_lo_d  = sync2_q;
      if (os_cnt_q == OS_W'(SAMPLE_MID)) s_mid_d = sync2_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_START;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
        end
      end
      ST_START: begin
        if (at_hi && maj)  state_d = ST_IDLE;
        else if (at_end)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_hi) shift_d = {maj, shift_q[DATA_W-1:1]};
        if (at_end) begin
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          else bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      ST_PARITY: begin
        if (at_hi)  par_err_d = maj ^ (^shift_q) ^ PARITY_ODD;
        if (at_end) state_d = ST_STOP;
      end
      // Decide mid-stop so a following start edge right at the stop-bit end is caught.
      ST_STOP: begin
        if (at_hi) begin
          if (!maj) begin
            ferr_d   = 1'b1;
            state_d  = ST_BREAK;
            os_cnt_d = '0;
          end else if (par_err_q) begin
            perr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rx_data_d = shift_q;
            new_d     = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      // os_cnt doubles as the consecutive-high tick counter while waiting out a break.
      ST_BREAK: begin
        if (ce16) begin
          if (!sync2_q)                                os_cnt_d = '0;
          else if (os_cnt_q == OS_W'(OS_RATE - 1))     state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      s_lo_q    <= 1'b1;
      s_mid_q   <= 1'b1;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      rx_data_q <= '0;
      new_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      s_lo_q    <= s_lo_d;
      s_mid_q   <= s_mid_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      rx_data_q <= rx_data_d;
      new_q     <= new_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign new_rx_data   = new_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and an even-parity instance driven by serial frame tasks.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int BD_N  = 22;
  localparam int BD_P  = 8;
  localparam int BIT_N = 16 * BD_N;
  localparam int BIT_P = 16 * BD_P;
  localparam int EXP_LAT_N = 2 + (9 * 16 + 10) * BD_N + 1;
  localparam int LAT_TOL   = BD_N + 4;
  localparam int EV_DATA = 0;
  localparam int EV_PERR = 1;
  localparam int EV_FERR = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       ser_n, ser_p;
  logic [7:0] rx_data_n, rx_data_p;
  logic       new_n, perr_n, ferr_n, busy_n;
  logic       new_p, perr_p, ferr_p, busy_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] got_n[$], got_p[$], exp_n[$], exp_p[$];
  int obs_perr_n, obs_ferr_n, obs_perr_p, obs_ferr_p;
  int exp_perr_n, exp_ferr_n, exp_perr_p, exp_ferr_p;
  int anom_n = 0, anom_p = 0;
  bit prev_n = 0, prev_p = 0;
  int first_strobe_n = -1;
  logic [7:0] last_n = 8'h00, last_p = 8'h00;

  uart_rx_os #(.BAUD_DIV(BD_N), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_n (
    .clock(clock), .reset(reset), .ser_in(ser_n), .rx_data(rx_data_n),
    .new_rx_data(new_n), .rx_parity_err(perr_n), .rx_frame_err(ferr_n), .rx_busy(busy_n));

  uart_rx_os #(.BAUD_DIV(BD_P), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clock(clock), .reset(reset), .ser_in(ser_p), .rx_data(rx_data_p),
    .new_rx_data(new_p), .rx_parity_err(perr_p), .rx_frame_err(ferr_p), .rx_busy(busy_p));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Strobe recorder; also flags overlapping or consecutive-cycle strobes.
  always @(negedge clock) begin
    int sn, sp;
    if (reset) begin
      sn = int'(new_n) + int'(perr_n) + int'(ferr_n);
      sp = int'(new_p) + int'(perr_p) + int'(ferr_p);
      if (new_n) begin
        got_n.push_back(rx_data_n);
        if (first_strobe_n < 0) first_strobe_n = cyc;
      end
      if (perr_n) obs_perr_n++;
      if (ferr_n) obs_ferr_n++;
      if (new_p)  got_p.push_back(rx_data_p);
      if (perr_p) obs_perr_p++;
      if (ferr_p) obs_ferr_p++;
      if (sn > 1 || (sn > 0 && prev_n)) anom_n++;
      if (sp > 1 || (sp > 0 && prev_p)) anom_p++;
      prev_n = (sn > 0);
      prev_p = (sp > 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Frame outcome from the protocol rules: stop low -> framing error, bad parity -> parity error.
  function automatic int predict(input logic [7:0] d, input bit par_en, input bit par_odd,
                                 input bit par_bit, input bit stop);
    if (!stop) return EV_FERR;
    if (par_en && ((($countones(d) + int'(par_bit)) % 2) != int'(par_odd))) return EV_PERR;
    return EV_DATA;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_line(input bit p, input logic v);
    if (p) ser_p = v;
    else   ser_n = v;
  endtask

  task automatic idle(input bit p, input int n);
    set_line(p, 1'b1);
    wait_cyc(n);
  endtask

  task automatic send_frame(input bit p, input logic [7:0] d, input bit use_par,
                            input bit par_bit, input bit stop, input int bit_cyc);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (use_par) bits.push_back(par_bit);
    bits.push_back(stop);
    foreach (bits[i]) begin
      set_line(p, bits[i]);
      wait_cyc(bit_cyc);
    end
  endtask

  task automatic frame_n(input logic [7:0] d, input bit stop, input int bit_cyc);
    int ev;
    ev = predict(d, 1'b0, 1'b0, 1'b0, stop);
    if (ev == EV_DATA) begin exp_n.push_back(d); last_n = d; end
    else if (ev == EV_PERR) exp_perr_n++;
    else exp_ferr_n++;
    send_frame(1'b0, d, 1'b0, 1'b0, stop, bit_cyc);
  endtask

  task automatic frame_p(input logic [7:0] d, input bit par_bit, input bit stop);
    int ev;
    ev = predict(d, 1'b1, 1'b0, par_bit, stop);
    if (ev == EV_DATA) begin exp_p.push_back(d); last_p = d; end
    else if (ev == EV_PERR) exp_perr_p++;
    else exp_ferr_p++;
    send_frame(1'b1, d, 1'b1, par_bit, stop, BIT_P);
  endtask

  task automatic clear_obs();
    got_n.delete(); got_p.delete(); exp_n.delete(); exp_p.delete();
    obs_perr_n = 0; obs_ferr_n = 0; obs_perr_p = 0; obs_ferr_p = 0;
    exp_perr_n = 0; exp_ferr_n = 0; exp_perr_p = 0; exp_ferr_p = 0;
    first_strobe_n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ser_n = 1'b1; ser_p = 1'b1;
    clear_obs();
    wait_cyc(3);
    checks++; if (rx_data_n !== 8'h00) begin errors++; $display("FAIL reset_data_n: got %h expected 00", rx_data_n); end
    checks++; if ({new_n, perr_n, ferr_n, busy_n} !== 4'b0000) begin errors++; $display("FAIL reset_flags_n: got %b expected 0000", {new_n, perr_n, ferr_n, busy_n}); end
    checks++; if (rx_data_p !== 8'h00) begin errors++; $display("FAIL reset_data_p: got %h expected 00", rx_data_p); end
    checks++; if ({new_p, perr_p, ferr_p, busy_p} !== 4'b0000) begin errors++; $display("FAIL reset_flags_p: got %b expected 0000", {new_p, perr_p, ferr_p, busy_p}); end
    reset = 1'b1;
    wait_cyc(40);
  endtask

  task automatic test_nominal();
    int c0, lat;
    clear_obs();
    c0 = cyc;
    frame_n(8'hA5, 1'b1, BIT_N);
    idle(1'b0, BIT_N);
    checks++;
    if (got_n.size() != exp_n.size()) begin errors++; $display("FAIL nominal_count: got %0d strobes expected %0d", got_n.size(), exp_n.size()); end
    else foreach (exp_n[i]) begin checks++; if (got_n[i] !== exp_n[i]) begin errors++; $display("FAIL nominal_data[%0d]: got %h expected %h", i, got_n[i], exp_n[i]); end end
    checks++; if (rx_data_n !== last_n) begin errors++; $display("FAIL nominal_rx_data: got %h expected %h", rx_data_n, last_n); end
    checks++; if (obs_perr_n + obs_ferr_n != 0) begin errors++; $display("FAIL nominal_errs: got %0d error strobes expected 0", obs_perr_n + obs_ferr_n); end
    lat = first_strobe_n - c0;
    checks++; if (first_strobe_n < 0 || lat < EXP_LAT_N - LAT_TOL || lat > EXP_LAT_N + LAT_TOL) begin errors++; $display("FAIL nominal_latency: got %0d cycles expected %0d +/- %0d", lat, EXP_LAT_N, LAT_TOL); end
    checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL nominal_busy: got %b expected 0", busy_n); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[4];
    seq = '{8'h00, 8'hFF, 8'h55, 8'h0D};
    clear_obs();
    foreach (seq[i]) frame_n(seq[i], 1'b1, BIT_N);
    idle(1'b0, BIT_N);
    checks++;
    if (got_n.size() != exp_n.size()) begin errors++; $display("FAIL b2b_count: got %0d strobes expected %0d", got_n.size(), exp_n.size()); end
    else foreach (exp_n[i]) begin checks++; if (got_n[i] !== exp_n[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_n[i], exp_n[i]); end end
    checks++; if (obs_perr_n + obs_ferr_n != 0) begin errors++; $display("FAIL b2b_errs: got %0d error strobes expected 0", obs_perr_n + obs_ferr_n); end
  endtask

  task automatic test_glitch();
    clear_obs();
    set_line(1'b0, 1'b0);
    wait_cyc(3 * BD_N);
    checks++; if (busy_n !== 1'b1) begin errors++; $display("FAIL glitch_detect: busy got %b expected 1", busy_n); end
    idle(1'b0, 24 * BD_N);
    checks++; if (got_n.size() != 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes expected 0", got_n.size()); end
    checks++; if (obs_perr_n + obs_ferr_n != 0) begin errors++; $display("FAIL glitch_errs: got %0d error strobes expected 0", obs_perr_n + obs_ferr_n); end
    checks++; if (rx_data_n !== last_n) begin errors++; $display("FAIL glitch_rx_data: got %h expected %h", rx_data_n, last_n); end
    checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy_n); end
  endtask

  task automatic test_framing();
    clear_obs();
    frame_n(8'h3C, 1'b0, BIT_N);
    set_line(1'b0, 1'b0);
    wait_cyc(30 * BIT_N);
    idle(1'b0, 24 * BD_N);
    checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL break_exit: busy got %b expected 0", busy_n); end
    checks++; if (rx_data_n !== last_n) begin errors++; $display("FAIL break_rx_data: got %h expected %h", rx_data_n, last_n); end
    frame_n(8'h12, 1'b1, BIT_N);
    idle(1'b0, BIT_N);
    checks++; if (obs_ferr_n != exp_ferr_n) begin errors++; $display("FAIL frame_err_count: got %0d expected %0d", obs_ferr_n, exp_ferr_n); end
    checks++; if (obs_perr_n != 0) begin errors++; $display("FAIL frame_perr: got %0d expected 0", obs_perr_n); end
    checks++;
    if (got_n.size() != exp_n.size()) begin errors++; $display("FAIL frame_count: got %0d strobes expected %0d", got_n.size(), exp_n.size()); end
    else foreach (exp_n[i]) begin checks++; if (got_n[i] !== exp_n[i]) begin errors++; $display("FAIL frame_data[%0d]: got %h expected %h", i, got_n[i], exp_n[i]); end end
  endtask

  task automatic test_parity();
    clear_obs();
    frame_p(8'h07, 1'b1, 1'b1);
    idle(1'b1, BIT_P);
    frame_p(8'h07, 1'b0, 1'b1);
    idle(1'b1, BIT_P);
    checks++;
    if (got_p.size() != exp_p.size()) begin errors++; $display("FAIL parity_count: got %0d strobes expected %0d", got_p.size(), exp_p.size()); end
    else foreach (exp_p[i]) begin checks++; if (got_p[i] !== exp_p[i]) begin errors++; $display("FAIL parity_data[%0d]: got %h expected %h", i, got_p[i], exp_p[i]); end end
    checks++; if (obs_perr_p != exp_perr_p) begin errors++; $display("FAIL parity_err_count: got %0d expected %0d", obs_perr_p, exp_perr_p); end
    checks++; if (obs_ferr_p != 0) begin errors++; $display("FAIL parity_ferr: got %0d expected 0", obs_ferr_p); end
    checks++; if (rx_data_p !== last_p) begin errors++; $display("FAIL parity_rx_data: got %h expected %h", rx_data_p, last_p); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h4A;
    clear_obs();
    set_line(1'b0, 1'b0);
    wait_cyc(BIT_N);
    for (int i = 0; i < 4; i++) begin set_line(1'b0, d[i]); wait_cyc(BIT_N); end
    set_line(1'b0, d[4]);
    wait_cyc(BIT_N / 2);
    checks++; if (busy_n !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b expected 1", busy_n); end
    reset = 1'b0;
    #1;
    last_n = 8'h00; last_p = 8'h00;
    checks++; if ({new_n, perr_n, ferr_n, busy_n} !== 4'b0000) begin errors++; $display("FAIL abort_flags_n: got %b expected 0000", {new_n, perr_n, ferr_n, busy_n}); end
    checks++; if (rx_data_n !== 8'h00) begin errors++; $display("FAIL abort_data_n: got %h expected 00", rx_data_n); end
    checks++; if (rx_data_p !== 8'h00) begin errors++; $display("FAIL abort_data_p: got %h expected 00", rx_data_p); end
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(2 * BIT_N);
    checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL low_after_reset: busy got %b expected 0", busy_n); end
    idle(1'b0, 2 * BIT_N);
    frame_n(8'h81, 1'b1, BIT_N);
    idle(1'b0, BIT_N);
    checks++;
    if (got_n.size() != exp_n.size()) begin errors++; $display("FAIL post_reset_count: got %0d strobes expected %0d", got_n.size(), exp_n.size()); end
    else foreach (exp_n[i]) begin checks++; if (got_n[i] !== exp_n[i]) begin errors++; $display("FAIL post_reset_data[%0d]: got %h expected %h", i, got_n[i], exp_n[i]); end end
    checks++; if (obs_perr_n + obs_ferr_n != 0) begin errors++; $display("FAIL post_reset_errs: got %0d error strobes expected 0", obs_perr_n + obs_ferr_n); end
  endtask

  task automatic test_skew();
    clear_obs();
    frame_n(8'hC3, 1'b1, BIT_N * 102 / 100);
    idle(1'b0, BIT_N);
    frame_n(8'hC3, 1'b1, BIT_N * 98 / 100);
    idle(1'b0, BIT_N);
    checks++;
    if (got_n.size() != exp_n.size()) begin errors++; $display("FAIL skew_count: got %0d strobes expected %0d", got_n.size(), exp_n.size()); end
    else foreach (exp_n[i]) begin checks++; if (got_n[i] !== exp_n[i]) begin errors++; $display("FAIL skew_data[%0d]: got %h expected %h", i, got_n[i], exp_n[i]); end end
    checks++; if (obs_perr_n + obs_ferr_n != 0) begin errors++; $display("FAIL skew_errs: got %0d error strobes expected 0", obs_perr_n + obs_ferr_n); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit pb;
    clear_obs();
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      frame_n(d, 1'b1, BIT_N);
      idle(1'b0, int'($urandom_range(0, 2)) * BD_N);
    end
    idle(1'b0, BIT_N);
    for (int i = 0; i < 5; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      frame_p(d, pb, 1'b1);
      idle(1'b1, int'($urandom_range(0, 2)) * BD_P);
    end
    idle(1'b1, BIT_P);
    checks++;
    if (got_n.size() != exp_n.size()) begin errors++; $display("FAIL rand_n_count: got %0d strobes expected %0d", got_n.size(), exp_n.size()); end
    else foreach (exp_n[i]) begin checks++; if (got_n[i] !== exp_n[i]) begin errors++; $display("FAIL rand_n_data[%0d]: got %h expected %h", i, got_n[i], exp_n[i]); end end
    checks++;
    if (got_p.size() != exp_p.size()) begin errors++; $display("FAIL rand_p_count: got %0d strobes expected %0d", got_p.size(), exp_p.size()); end
    else foreach (exp_p[i]) begin checks++; if (got_p[i] !== exp_p[i]) begin errors++; $display("FAIL rand_p_data[%0d]: got %h expected %h", i, got_p[i], exp_p[i]); end end
    checks++; if (obs_perr_p != exp_perr_p) begin errors++; $display("FAIL rand_p_perr: got %0d expected %0d", obs_perr_p, exp_perr_p); end
    checks++; if (obs_ferr_p + obs_ferr_n + obs_perr_n != 0) begin errors++; $display("FAIL rand_other_errs: got %0d expected 0", obs_ferr_p + obs_ferr_n + obs_perr_n); end
    checks++; if (rx_data_p !== last_p) begin errors++; $display("FAIL rand_p_rx_data: got %h expected %h", rx_data_p, last_p); end
  endtask

  task automatic test_strobe_rules();
    checks++; if (anom_n != 0) begin errors++; $display("FAIL strobe_rules_n: got %0d violations expected 0", anom_n); end
    checks++; if (anom_p != 0) begin errors++; $display("FAIL strobe_rules_p: got %0d violations expected 0", anom_p); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_parity();
    test_reset_midframe();
    test_skew();
    test_random();
    test_strobe_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
